// File: rtl/interval_timer_arbiter_pkg.sv
// Shared encodings for the interval timer arbiter.
// Holds FSM states, owner codes and the round-robin pick helper.
package interval_timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    // On a tie the requester that did not own the last grant wins.
    function automatic logic rr_pick(
        input logic req_a,
        input logic req_b,
        input logic last_owner
    );
        logic pick;
        if (req_a && req_b) begin
            pick = ~last_owner;
        end else if (req_b) begin
            pick = OWN_B;
        end else begin
            pick = OWN_A;
        end
        return pick;
    endfunction

endpackage

// File: rtl/interval_timer_arbiter_counter_en_clr.sv
// W-bit up-counter with synchronous clear over enable.
// Asynchronous active-low reset returns it to zero.
module counter_en_clr #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (en) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin sequencer sharing one interval counter between A and B.
// Four-phase req/ack per client; ack rises once the count reaches N.
module interval_timer_arbiter
    import interval_timer_arbiter_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         req_a,
    input  logic [W-1:0] n_a,
    output logic         ack_a,
    input  logic         req_b,
    input  logic [W-1:0] n_b,
    output logic         ack_b,
    output logic         busy,
    output logic         owner,
    output logic [W-1:0] count
);

    state_t       r_state;
    state_t       w_next;
    logic         r_owner;
    logic [W-1:0] r_n;
    logic         r_ack_a;
    logic         r_ack_b;

    logic         w_req_gnt;
    logic         w_pick;
    logic         w_grant;
    logic         w_clr;
    logic         w_en;
    logic         w_set_ack;
    logic         w_drop_ack;
    logic [W-1:0] w_count;

    counter_en_clr #(.W(W)) u_cnt (
        .clock  (clock),
        .reset_ (reset_),
        .en     (w_en),
        .clr    (w_clr),
        .value  (w_count)
    );

    assign w_req_gnt = (r_owner == OWN_B) ? req_b : req_a;
    assign w_pick    = rr_pick(req_a, req_b, r_owner);

    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_clr      = 1'b0;
        w_en       = 1'b0;
        w_set_ack  = 1'b0;
        w_drop_ack = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_a || req_b) begin
                    w_next  = COUNT;
                    w_grant = 1'b1;
                    w_clr   = 1'b1;
                end
            end
            COUNT: begin
                // Owner withdrew mid-count: abandon without acking.
                if (!w_req_gnt) begin
                    w_next = IDLE;
                    w_clr  = 1'b1;
                end else if (w_count == r_n) begin
                    w_next    = DONE;
                    w_set_ack = 1'b1;
                end else begin
                    w_en = 1'b1;
                end
            end
            DONE: begin
                if (!w_req_gnt) begin
                    w_next     = IDLE;
                    w_clr      = 1'b1;
                    w_drop_ack = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
                w_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state <= IDLE;
            r_owner <= OWN_B;
            r_n     <= '0;
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner <= w_pick;
                r_n     <= (w_pick == OWN_B) ? n_b : n_a;
            end
            if (w_set_ack) begin
                r_ack_a <= (r_owner == OWN_A);
                r_ack_b <= (r_owner == OWN_B);
            end else if (w_drop_ack) begin
                r_ack_a <= 1'b0;
                r_ack_b <= 1'b0;
            end
        end
    end

    assign ack_a = r_ack_a;
    assign ack_b = r_ack_b;
    assign busy  = (r_state != IDLE);
    assign owner = r_owner;
    assign count = w_count;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Scoreboard bench for interval_timer_arbiter: stimulus queues expected
// acks (who, edge, count); a negedge monitor pops them on each ack rise.
module tb_interval_timer_arbiter;

    localparam int W = 3;

    typedef struct {
        logic who;
        int   cyc;
        int   cnt;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_ = 1'b0;
    logic         req_a = 1'b0;
    logic [W-1:0] n_a = '0;
    logic         ack_a;
    logic         req_b = 1'b0;
    logic [W-1:0] n_b = '0;
    logic         ack_b;
    logic         busy;
    logic         owner;
    logic [W-1:0] count;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    interval_timer_arbiter #(.W(W)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .req_a  (req_a),
        .n_a    (n_a),
        .ack_a  (ack_a),
        .req_b  (req_b),
        .n_b    (n_b),
        .ack_b  (ack_b),
        .busy   (busy),
        .owner  (owner),
        .count  (count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (ack_a && ack_b) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_overlap: got both acks high expected one (cyc %0d)", cyc);
        end
        if ((ack_a && !prev_a) || (ack_b && !prev_b)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack_a=%0d ack_b=%0d expected none (cyc %0d)",
                         ack_a, ack_b, cyc);
            end else begin
                e = sb.pop_front();
                chk("ack_who", int'(ack_b), int'(e.who));
                chk("ack_cyc", cyc, e.cyc);
                chk("ack_count", int'(count), e.cnt);
                chk("ack_owner", int'(owner), int'(e.who));
            end
        end
        prev_a = ack_a;
        prev_b = ack_b;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_ack(input logic who, input int budget);
        int k;
        k = 0;
        while (((who ? ack_b : ack_a) !== 1'b1) && k < budget) begin
            tick();
            k++;
        end
        if ((who ? ack_b : ack_a) !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack from %0d expected within %0d cycles",
                     who, budget);
        end
    endtask

    task automatic push(input logic who, input int c, input int cnt);
        exp_t e;
        e.who = who;
        e.cyc = c;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        #1 reset_ = 1'b0;
        tick(2);
        reset_ = 1'b1;
    endtask

    initial begin
        int c;
        int g;
        logic who;
        int nn;

        tick(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_owner", int'(owner), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_ack", int'(ack_a | ack_b), 0);
        reset_ = 1'b1;
        tick();

        // Reset in the middle of a count
        req_a = 1'b1;
        n_a   = 3'd5;
        tick(2);
        chk("mid_busy", int'(busy), 1);
        chk("mid_count", int'(count), 1);
        chk("mid_owner", int'(owner), 0);
        #1 reset_ = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_owner", int'(owner), 1);
        chk("arst_ack", int'(ack_a), 0);
        req_a = 1'b0;
        tick();
        reset_ = 1'b1;
        tick();
        chk("post_rst_idle", int'(busy), 0);

        // Single request A, N=3, n_a changed after grant
        c = cyc;
        req_a = 1'b1;
        n_a   = 3'd3;
        push(1'b0, c + 5, 3);
        tick();
        n_a = 3'd0;
        chk("seq_c0", int'(count), 0);
        tick();
        chk("seq_c1", int'(count), 1);
        tick();
        chk("seq_c2", int'(count), 2);
        tick();
        chk("seq_c3", int'(count), 3);
        chk("seq_noack", int'(ack_a), 0);
        wait_ack(1'b0, 10);
        req_a = 1'b0;
        tick();
        chk("drop_ack", int'(ack_a), 0);
        chk("drop_busy", int'(busy), 0);
        chk("drop_count", int'(count), 0);

        // N=0 on B
        c = cyc;
        req_b = 1'b1;
        n_b   = 3'd0;
        push(1'b1, c + 2, 0);
        wait_ack(1'b1, 10);
        req_b = 1'b0;
        tick();

        // N=7 on A: full range, holds at 7 in DONE
        c = cyc;
        req_a = 1'b1;
        n_a   = 3'd7;
        push(1'b0, c + 9, 7);
        wait_ack(1'b0, 20);
        tick(2);
        chk("max_hold_count", int'(count), 7);
        chk("max_hold_ack", int'(ack_a), 1);
        req_a = 1'b0;
        tick();

        // Simultaneous requests right after reset
        do_reset();
        tick();
        c = cyc;
        req_a = 1'b1;
        req_b = 1'b1;
        n_a   = 3'd2;
        n_b   = 3'd1;
        push(1'b0, c + 4, 2);
        push(1'b1, c + 8, 1);
        wait_ack(1'b0, 10);
        req_a = 1'b0;
        tick();
        chk("gap_idle", int'(busy), 0);
        tick();
        chk("b_grant_owner", int'(owner), 1);
        chk("b_grant_busy", int'(busy), 1);
        wait_ack(1'b1, 10);
        req_b = 1'b0;
        tick();

        // Fairness: both requesters keep coming back
        n_a = 3'd1;
        n_b = 3'd2;
        c = cyc;
        req_a = 1'b1;
        req_b = 1'b1;
        g = c + 1;
        for (int k = 0; k < 4; k++) begin
            nn = (k % 2 == 0) ? 1 : 2;
            push(logic'(k % 2), g + nn + 1, nn);
            g = g + nn + 3;
        end
        for (int k = 0; k < 4; k++) begin
            who = logic'(k % 2);
            wait_ack(who, 20);
            if (who) req_b = 1'b0;
            else req_a = 1'b0;
            if (k == 3) req_a = 1'b0;
            tick();
            if (k != 3) begin
                if (who) req_b = 1'b1;
                else req_a = 1'b1;
            end
        end
        tick(2);
        chk("fair_idle", int'(busy), 0);

        // Abort: A drops at count=2, pending B served next
        req_a = 1'b1;
        n_a   = 3'd6;
        tick(3);
        chk("abort_pre_count", int'(count), 2);
        c = cyc;
        req_a = 1'b0;
        req_b = 1'b1;
        n_b   = 3'd0;
        push(1'b1, c + 3, 0);
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_count", int'(count), 0);
        chk("abort_ack", int'(ack_a), 0);
        tick();
        chk("abort_b_owner", int'(owner), 1);
        chk("abort_b_busy", int'(busy), 1);
        wait_ack(1'b1, 10);
        req_b = 1'b0;
        tick(3);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end within 200000 time units");
        $fatal(1);
    end

endmodule
